sram_emulator: RTL and testbench

On-chip responder for the asynchronous 16-bit PSRAM pin interface driven by the CPU/VGA SRAM controller. It backs the interface with internal block RAM, so the full memory path runs in simulation and on boards without external PSRAM. It sits where the external device would: every `sram_*` controller output becomes an input here, and `sram_data` is shared bidirectionally. Only asynchronous mode is supported; writes commit on the rising edge of WE.

---
 rtl/sram_emu_pkg.sv | 24 ++
 rtl/sram_emu_mem.sv | 57 +++++
 rtl/sram_emulator.sv | 174 +++++++++++++++++
 tb/tb_sram_emulator.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_emu_pkg.sv
// Shared constants and types for the on-chip PSRAM responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sram_emu_pkg;

    // Returned for reads that fall outside the backed range or hit the config register.
    localparam logic [15:0] OOB_PATTERN = 16'hDEAD;
    localparam int          LANE_W      = 8;

    // Active-high byte-lane enables, {ub, lb}.
    typedef struct packed {
        logic ub;
        logic lb;
    } lane_en_t;

    // The pins are active-low; flip them once here so the datapath reads naturally.
    function automatic lane_en_t lane_en(input logic lb_n, input logic ub_n);
        lane_en_t r;
        r.ub = !ub_n;
        r.lb = !lb_n;
        return r;
    endfunction

endpackage

// File: rtl/sram_emu_mem.sv
// Halfword RAM backing the PSRAM responder, byte-lane writes on posedge, registered read on negedge.
// Latency: write visible to the next negedge read; read data valid half a cycle after rd_idx_i changes.
// Backpressure: none; one write and one read per cycle, always accepted.
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset (clears the read register only)
//   wr_en_i       : per-lane write enables {ub, lb}
//   wr_idx_i/dat_i: write halfword index and data
//   rd_idx_i      : read halfword index
//   rd_oob_i      : load OOB_PATTERN instead of memory contents
//   rd_dat_o      : registered read data
module sram_emu_mem
    import sram_emu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  lane_en_t              wr_en_i,
    input  logic [ADDR_W-1:0]     wr_idx_i,
    input  logic [2*LANE_W-1:0]   wr_dat_i,
    input  logic [ADDR_W-1:0]     rd_idx_i,
    input  logic                  rd_oob_i,
    output logic [2*LANE_W-1:0]   rd_dat_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Split by lane so each half gets its own write enable.
    logic [LANE_W-1:0]   mem_lo_q [0:DEPTH-1];
    logic [LANE_W-1:0]   mem_hi_q [0:DEPTH-1];
    logic [2*LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en_i.lb) begin
            mem_lo_q[wr_idx_i] <= wr_dat_i[LANE_W-1:0];
        end
        if (wr_en_i.ub) begin
            mem_hi_q[wr_idx_i] <= wr_dat_i[2*LANE_W-1:LANE_W];
        end
    end

    // Negedge read: a posedge commit is already in the array, so same-cycle
    // read-after-write returns the new data.
    always_ff @(negedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_oob_i) begin
            rd_q <= OOB_PATTERN;
        end else begin
            rd_q <= {mem_hi_q[rd_idx_i], mem_lo_q[rd_idx_i]};
        end
    end

    assign rd_dat_o = rd_q;

endmodule

// File: rtl/sram_emulator.sv
// On-chip stand-in for the async 16-bit PSRAM: captures writes while WE is low, commits on WE rise, drives reads from block RAM.
// Latency: read data on the bus half a cycle after the address changes; write committed at the posedge that sees WE rise.
// Backpressure: none; the controller's fixed read/write sequences are always met.
//
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   sram_clk, sram_adv       : unused (async mode only)
//   sram_cre                 : config-register enable; any access with it high is rejected
//   sram_ce/oe/we/lb/ub      : active-low chip, output, write and byte-lane enables
//   sram_addr[23:1]          : halfword address
//   sram_data                : shared bidirectional data bus
//   oob_err                  : sticky, set by a rejected commit or a rejected read being driven
//   rd_count, wr_count       : access statistics, built only when SRAM_EMU_STATS_EN is defined (else 0)
module sram_emulator
    import sram_emu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_clk,
    input  logic        sram_adv,
    input  logic        sram_cre,
    input  logic        sram_ce,
    input  logic        sram_oe,
    input  logic        sram_we,
    input  logic        sram_lb,
    input  logic        sram_ub,
    input  logic [23:1] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        oob_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    logic unused_async_pins;
    assign unused_async_pins = &{1'b0, sram_clk, sram_adv};

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              drv;
    logic              capture;
    logic              commit;

    logic              we_q;
    logic              abort_q,   abort_d;
    logic              cap_vld_q, cap_vld_d;
    logic              oob_wr_q,  oob_wr_d;
    logic              oob_rd_q;
    logic [ADDR_W-1:0] cap_idx_q;
    logic              cap_ok_q;
    logic [15:0]       cap_dat_q;
    lane_en_t          cap_lanes_q;

    lane_en_t          mem_wr_en;
    logic [15:0]       rd_dat;

    assign idx      = sram_addr[ADDR_W:1];
    // Shift rather than slice so the upper-bit check stays legal for any ADDR_W.
    assign in_range = ((sram_addr >> ADDR_W) == '0) && !sram_cre;

    assign capture  = !rst && !sram_ce && !sram_we;
    assign commit   = !rst && !we_q && sram_we && cap_vld_q;

    // we_q keeps the bus quiet in the one-cycle WE-high gap between the two
    // halves of a 32-bit write, where the controller may still be driving.
    assign drv      = !rst && !sram_ce && !sram_oe && sram_we && we_q;

    // abort_q marks a write that was already under way when reset hit; its
    // remaining low cycles must not re-arm the capture, so it never commits.
    always_comb begin
        cap_vld_d = cap_vld_q;
        abort_d   = abort_q;
        oob_wr_d  = oob_wr_q;
        if (sram_we) begin
            abort_d = 1'b0;
        end
        if (capture) begin
            cap_vld_d = !abort_q;
        end else if (commit) begin
            cap_vld_d = 1'b0;
        end
        if (commit && !cap_ok_q) begin
            oob_wr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b1;
            cap_vld_q <= 1'b0;
            abort_q   <= !sram_we;
            oob_wr_q  <= 1'b0;
        end else begin
            we_q      <= sram_we;
            cap_vld_q <= cap_vld_d;
            abort_q   <= abort_d;
            oob_wr_q  <= oob_wr_d;
        end
    end

    // Capture payload needs no reset; it is qualified by cap_vld_q.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_idx_q   <= idx;
            cap_ok_q    <= in_range;
            cap_dat_q   <= sram_data;
            cap_lanes_q <= lane_en(sram_lb, sram_ub);
        end
    end

    // Rejected reads are flagged when they actually reach the bus.
    always_ff @(negedge clk) begin
        if (rst) begin
            oob_rd_q <= 1'b0;
        end else if (drv && !in_range) begin
            oob_rd_q <= 1'b1;
        end
    end

    assign oob_err   = oob_wr_q | oob_rd_q;
    assign mem_wr_en = (commit && cap_ok_q) ? cap_lanes_q : '0;

    sram_emu_mem #(
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (mem_wr_en),
        .wr_idx_i (cap_idx_q),
        .wr_dat_i (cap_dat_q),
        .rd_idx_i (idx),
        .rd_oob_i (!in_range),
        .rd_dat_o (rd_dat)
    );

    assign sram_data[LANE_W-1:0]        = (drv && !sram_lb) ? rd_dat[LANE_W-1:0]        : {LANE_W{1'bz}};
    assign sram_data[2*LANE_W-1:LANE_W] = (drv && !sram_ub) ? rd_dat[2*LANE_W-1:LANE_W] : {LANE_W{1'bz}};

`ifdef SRAM_EMU_STATS_EN
    logic [31:0]       rd_cnt_q;
    logic [31:0]       wr_cnt_q;
    logic              drv_prev_q;
    logic [ADDR_W-1:0] prev_idx_q;

    // A read is counted once per new driven address, so a held address is one read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            drv_prev_q <= 1'b0;
            prev_idx_q <= '0;
        end else begin
            drv_prev_q <= drv;
            if (drv) begin
                prev_idx_q <= idx;
            end
            if (drv && (!drv_prev_q || (idx != prev_idx_q))) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (commit) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_emulator.sv
// Self-checking bench for sram_emulator: emulates the controller's pin sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_emulator;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_clk;
    logic        sram_adv;
    logic        cre;
    logic        ce;
    logic        oe;
    logic        we;
    logic        lb;
    logic        ub;
    logic [23:1] addr;
    wire  [15:0] sram_data;
    logic        oob_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    logic        tb_drv;
    logic [15:0] tb_dat;

    assign sram_data = tb_drv ? tb_dat : 16'hzzzz;

    always #5 clk = ~clk;

    sram_emulator #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sram_clk  (sram_clk),
        .sram_adv  (sram_adv),
        .sram_cre  (cre),
        .sram_ce   (ce),
        .sram_oe   (oe),
        .sram_we   (we),
        .sram_lb   (lb),
        .sram_ub   (ub),
        .sram_addr (addr),
        .sram_data (sram_data),
        .oob_err   (oob_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain halfword array plus flag and access tallies.
    logic [15:0] mref [0:(1<<AW)-1];
    bit          oob_m;
    int unsigned wr_m;
    int unsigned rd_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce = 1'b1; oe = 1'b1; we = 1'b1; tb_drv = 1'b0; cre = 1'b0; lb = 1'b0; ub = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce = 1'b1; oe = 1'b1; we = 1'b1; tb_drv = 1'b0; cre = 1'b0; lb = 1'b0; ub = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc();
        oob_m = 1'b0; wr_m = 0; rd_m = 0;
    endtask

    // Controller halfword write: WE low two cycles, then one WE-high cycle.
    task automatic write16(input logic [22:0] a, input logic [15:0] d,
                           input logic lbn, input logic ubn, input logic c);
        ce = 1'b0; oe = 1'b1; we = 1'b0; addr = a; tb_dat = d; tb_drv = 1'b1;
        lb = lbn; ub = ubn; cre = c;
        cyc(); cyc();
        we = 1'b1; tb_drv = 1'b0;
        cyc();
    endtask

    // Controller halfword read: sampled one full cycle after the address is set.
    task automatic read16(input logic [22:0] a, input logic lbn, input logic ubn,
                          input logic c, output logic [15:0] q);
        ce = 1'b0; oe = 1'b0; we = 1'b1; addr = a; lb = lbn; ub = ubn; cre = c; tb_drv = 1'b0;
        cyc();
        q = sram_data;
        cyc();
    endtask

    function automatic bit in_rng(input logic [22:0] a, input logic c);
        return ((a >> AW) == 23'd0) && !c;
    endfunction

    task automatic do_write(input logic [22:0] a, input logic [15:0] d,
                            input logic lbn, input logic ubn, input logic c);
        write16(a, d, lbn, ubn, c);
        idle();
        wr_m++;
        if (!in_rng(a, c)) begin
            oob_m = 1'b1;
        end else begin
            if (!lbn) mref[a[AW-1:0]][7:0]  = d[7:0];
            if (!ubn) mref[a[AW-1:0]][15:8] = d[15:8];
        end
    endtask

    task automatic do_read(input string name, input logic [22:0] a, input logic c);
        logic [15:0] q;
        logic [15:0] exp;
        read16(a, 1'b0, 1'b0, c, q);
        idle();
        rd_m++;
        if (in_rng(a, c)) begin
            exp = mref[a[AW-1:0]];
        end else begin
            exp = 16'hDEAD;
            oob_m = 1'b1;
        end
        check(name, {16'h0, q}, {16'h0, exp});
    endtask

    typedef struct packed {
        logic        is_wr;
        logic [22:0] a;
        logic [15:0] d;
        logic        lbn;
        logic        ubn;
        logic        cre;
        logic [15:0] exp;
        logic        exp_oob;
    } vec_t;

    localparam int NVEC = 12;
    vec_t tbl [NVEC];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic [15:0] q2;
        logic [22:0] a;
        logic [15:0] d;
        int          k;
        logic        c;
        logic        lbn;
        logic        ubn;
        logic [31:0] exp_wr;
        logic [31:0] exp_rd;

        sram_clk = 1'b0; sram_adv = 1'b0; addr = '0; tb_dat = '0;
        do_reset();

        // Reset state.
        check("reset_oob_err", {31'h0, oob_err}, 32'h0);
        check("reset_rd_count", rd_count, 32'h0);
        check("reset_wr_count", wr_count, 32'h0);

        // 32-bit round trip at byte address 0x100: upper half at the lower halfword.
        write16(23'h80, 16'h1234, 1'b0, 1'b0, 1'b0);
        write16(23'h81, 16'h5678, 1'b0, 1'b0, 1'b0);
        read16(23'h80, 1'b0, 1'b0, 1'b0, q);
        read16(23'h81, 1'b0, 1'b0, 1'b0, q2);
        idle();
        check("rt32_read", {q, q2}, 32'h12345678);

        // Table of single accesses with hand-derived expectations.
        tbl[0]  = '{1'b1, 23'h0,      16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0};
        tbl[1]  = '{1'b1, 23'h5,      16'h1122, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0};
        tbl[2]  = '{1'b1, 23'h5,      16'hAABB, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0};
        tbl[3]  = '{1'b0, 23'h5,      16'h0,    1'b0, 1'b0, 1'b0, 16'h11BB, 1'b0};
        tbl[4]  = '{1'b1, 23'hFFF,    16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0};
        tbl[5]  = '{1'b0, 23'hFFF,    16'h0,    1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[6]  = '{1'b1, 23'h1000,   16'h7777, 1'b0, 1'b0, 1'b0, 16'h0,    1'b1};
        tbl[7]  = '{1'b0, 23'h0,      16'h0,    1'b0, 1'b0, 1'b0, 16'h0F0F, 1'b1};
        tbl[8]  = '{1'b0, 23'h1000,   16'h0,    1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b1};
        tbl[9]  = '{1'b0, 23'h5,      16'h0,    1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1};
        tbl[10] = '{1'b0, 23'h7FFFFF, 16'h0,    1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b1};
        tbl[11] = '{1'b0, 23'h5,      16'h0,    1'b0, 1'b0, 1'b0, 16'h11BB, 1'b1};
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].is_wr) begin
                write16(tbl[i].a, tbl[i].d, tbl[i].lbn, tbl[i].ubn, tbl[i].cre);
                idle();
            end else begin
                read16(tbl[i].a, tbl[i].lbn, tbl[i].ubn, tbl[i].cre, q);
                idle();
                check($sformatf("vec%0d_data", i), {16'h0, q}, {16'h0, tbl[i].exp});
            end
            check($sformatf("vec%0d_oob", i), {31'h0, oob_err}, {31'h0, tbl[i].exp_oob});
        end

        // Upper-lane-only read of 0x11BB: [15:8] driven, [7:0] left alone.
        read16(23'h5, 1'b1, 1'b0, 1'b0, q);
        idle();
        check("lane_ub_data", {24'h0, q[15:8]}, 32'h11);
        check("lane_lb_released", {31'h0, (q[7:0] === 8'hBB)}, 32'h0);

        // WE-high gap inside a write with OE held low: emulator must stay off the bus.
        write16(23'h9, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        idle();
        ce = 1'b0; oe = 1'b0; we = 1'b0; addr = 23'hA; tb_dat = 16'h3C3C; tb_drv = 1'b1;
        cyc(); cyc();
        we = 1'b1; tb_drv = 1'b0; addr = 23'h9;
        @(negedge clk);
        #2;
        q = sram_data;
        cyc();
        idle();
        check("gap_no_drive", {31'h0, (q === 16'h5A5A)}, 32'h0);
        read16(23'hA, 1'b0, 1'b0, 1'b0, q);
        idle();
        check("gap_write_commit", {16'h0, q}, 32'h3C3C);

        // Reset asserted while WE is low, released before WE rises: write discarded.
        write16(23'h7, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        idle();
        ce = 1'b0; oe = 1'b1; we = 1'b0; addr = 23'h7; tb_dat = 16'hFFFF; tb_drv = 1'b1;
        lb = 1'b0; ub = 1'b0; cre = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        we = 1'b1; tb_drv = 1'b0;
        cyc();
        idle();
        read16(23'h7, 1'b0, 1'b0, 1'b0, q);
        idle();
        check("rst_midwrite_data", {16'h0, q}, 32'hA5C3);
        check("rst_midwrite_oob", {31'h0, oob_err}, 32'h0);

        // CRE read alone raises the sticky flag.
        do_reset();
        read16(23'h5, 1'b0, 1'b0, 1'b1, q);
        idle();
        check("cre_read_data", {16'h0, q}, 32'hDEAD);
        check("cre_read_oob", {31'h0, oob_err}, 32'h1);

        // Statistics: three 32-bit writes and two 32-bit reads.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write16(23'h20 + 23'(2*i), 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
            write16(23'h21 + 23'(2*i), 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
            idle();
        end
        for (int i = 0; i < 2; i++) begin
            read16(23'h20 + 23'(2*i), 1'b0, 1'b0, 1'b0, q);
            read16(23'h21 + 23'(2*i), 1'b0, 1'b0, 1'b0, q2);
            idle();
            check($sformatf("stats_read%0d", i), {q, q2}, {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
        end
`ifdef SRAM_EMU_STATS_EN
        exp_wr = 32'd6; exp_rd = 32'd4;
`else
        exp_wr = 32'd0; exp_rd = 32'd0;
`endif
        check("stats_wr_count", wr_count, exp_wr);
        check("stats_rd_count", rd_count, exp_rd);

        // Randomized traffic over a small window against the reference model.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(23'(i), 16'($urandom), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            k   = $urandom_range(0, 9);
            a   = 23'($urandom_range(0, 15));
            d   = 16'($urandom);
            lbn = 1'($urandom_range(0, 1));
            ubn = 1'($urandom_range(0, 1));
            c   = 1'($urandom_range(0, 1));
            if (k <= 3) begin
                do_write(a, d, lbn, ubn, 1'b0);
            end else if (k == 4) begin
                if (!c) a = a | (23'($urandom_range(1, 2047)) << AW);
                do_write(a, d, lbn, ubn, c);
            end else if (k <= 8) begin
                do_read($sformatf("rand%0d_read", i), a, 1'b0);
            end else begin
                if (!c) a = a | (23'($urandom_range(1, 2047)) << AW);
                do_read($sformatf("rand%0d_oob_read", i), a, c);
            end
            if (k == 4 || k == 9) begin
                check($sformatf("rand%0d_oob", i), {31'h0, oob_err}, {31'h0, oob_m});
            end
        end
        check("rand_oob_final", {31'h0, oob_err}, {31'h0, oob_m});
`ifdef SRAM_EMU_STATS_EN
        exp_wr = wr_m; exp_rd = rd_m;
`else
        exp_wr = 32'd0; exp_rd = 32'd0;
`endif
        check("rand_wr_count", wr_count, exp_wr);
        check("rand_rd_count", rd_count, exp_rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
